// File: rtl/ramb18_tdp.sv
// True-dual-port 1024 x 18 block RAM (16 data + 2 parity) on a single clock.
// Each port has byte write enables, a selectable write mode, an optional output register and SSR.
module ramb18_tdp #(
    parameter bit          DOA_REG      = 1'b0,
    parameter bit          DOB_REG      = 1'b0,
    parameter logic [17:0] INIT_A       = 18'h00000,
    parameter logic [17:0] INIT_B       = 18'h00000,
    parameter logic [17:0] SRVAL_A      = 18'h00000,
    parameter logic [17:0] SRVAL_B      = 18'h00000,
    parameter string       WRITE_MODE_A = "WRITE_FIRST",
    parameter string       WRITE_MODE_B = "WRITE_FIRST"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] ADDRA,
    input  logic [13:0] ADDRB,
    input  logic [15:0] DIA,
    input  logic [15:0] DIB,
    input  logic [1:0]  DIPA,
    input  logic [1:0]  DIPB,
    input  logic        ENA,
    input  logic        ENB,
    input  logic [1:0]  WEA,
    input  logic [1:0]  WEB,
    input  logic        REGCEA,
    input  logic        REGCEB,
    input  logic        SSRA,
    input  logic        SSRB,
    output logic [15:0] DOA,
    output logic [15:0] DOB,
    output logic [1:0]  DOPA,
    output logic [1:0]  DOPB
);

    localparam logic [1:0] MODE_WF = 2'd0;
    localparam logic [1:0] MODE_RF = 2'd1;
    localparam logic [1:0] MODE_NC = 2'd2;

    localparam logic [1:0] MODE_A = (WRITE_MODE_A == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_A == "NO_CHANGE")  ? MODE_NC : MODE_WF;
    localparam logic [1:0] MODE_B = (WRITE_MODE_B == "READ_FIRST") ? MODE_RF :
                                    (WRITE_MODE_B == "NO_CHANGE")  ? MODE_NC : MODE_WF;

    // Word layout is {parity[1:0], data[15:0]}; lane n owns data[8n+7:8n] and parity[n].
    function automatic logic [17:0] merge_word(
        input logic [17:0] old_word,
        input logic [15:0] data,
        input logic [1:0]  par,
        input logic [1:0]  we
    );
        logic [17:0] w;
        w = old_word;
        if (we[0]) begin
            w[7:0]  = data[7:0];
            w[16]   = par[0];
        end
        if (we[1]) begin
            w[15:8] = data[15:8];
            w[17]   = par[1];
        end
        return w;
    endfunction

    logic [17:0] mem_r [0:1023];

    logic [9:0]  word_a_s;
    logic [9:0]  word_b_s;
    logic [17:0] rd_a_s;
    logic [17:0] rd_b_s;
    logic        wr_a_s;
    logic        wr_b_s;
    logic [17:0] merged_a_s;
    logic [17:0] merged_b_s;
    logic        collide_s;
    logic [17:0] wdata_b_s;
    logic [17:0] latch_a_nxt_s;
    logic [17:0] latch_b_nxt_s;
    logic [17:0] latch_a_r;
    logic [17:0] latch_b_r;
    logic [17:0] reg_a_r;
    logic [17:0] reg_b_r;
    logic [7:0]  unused_addr_s;

    assign word_a_s      = ADDRA[13:4];
    assign word_b_s      = ADDRB[13:4];
    assign unused_addr_s = {ADDRA[3:0], ADDRB[3:0]};
    assign rd_a_s        = mem_r[word_a_s];
    assign rd_b_s        = mem_r[word_b_s];
    assign wr_a_s        = ENA && (WEA != 2'b00);
    assign wr_b_s        = ENB && (WEB != 2'b00);
    assign merged_a_s    = merge_word(rd_a_s, DIA, DIPA, WEA);
    assign merged_b_s    = merge_word(rd_b_s, DIB, DIPB, WEB);
    assign collide_s     = wr_a_s && wr_b_s && (word_a_s == word_b_s);

    // Same-word double write: B's lanes are layered over A's merged word so B wins overlaps.
    always_comb begin
        wdata_b_s = merged_b_s;
        if (collide_s) begin
            wdata_b_s = merge_word(merged_a_s, DIB, DIPB, WEB);
        end else begin
            wdata_b_s = merged_b_s;
        end
    end

    // Array update; reads above see the pre-write word, giving read-old collision behaviour.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr_a_s) begin
                mem_r[word_a_s] <= merged_a_s;
            end
            if (wr_b_s) begin
                mem_r[word_b_s] <= wdata_b_s;
            end
        end
    end

    // Port A latch-stage next value.
    always_comb begin
        latch_a_nxt_s = latch_a_r;
        if (ENA) begin
            if (SSRA && !DOA_REG) begin
                latch_a_nxt_s = SRVAL_A;
            end else if (WEA != 2'b00) begin
                case (MODE_A)
                    MODE_RF: latch_a_nxt_s = rd_a_s;
                    MODE_NC: latch_a_nxt_s = latch_a_r;
                    default: latch_a_nxt_s = merged_a_s;
                endcase
            end else begin
                latch_a_nxt_s = rd_a_s;
            end
        end else begin
            latch_a_nxt_s = latch_a_r;
        end
    end

    // Port B latch-stage next value.
    always_comb begin
        latch_b_nxt_s = latch_b_r;
        if (ENB) begin
            if (SSRB && !DOB_REG) begin
                latch_b_nxt_s = SRVAL_B;
            end else if (WEB != 2'b00) begin
                case (MODE_B)
                    MODE_RF: latch_b_nxt_s = rd_b_s;
                    MODE_NC: latch_b_nxt_s = latch_b_r;
                    default: latch_b_nxt_s = merged_b_s;
                endcase
            end else begin
                latch_b_nxt_s = rd_b_s;
            end
        end else begin
            latch_b_nxt_s = latch_b_r;
        end
    end

    // Port A latch and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_a_r <= INIT_A;
            reg_a_r   <= INIT_A;
        end else begin
            latch_a_r <= latch_a_nxt_s;
            if (REGCEA) begin
                reg_a_r <= SSRA ? SRVAL_A : latch_a_r;
            end
        end
    end

    // Port B latch and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_b_r <= INIT_B;
            reg_b_r   <= INIT_B;
        end else begin
            latch_b_r <= latch_b_nxt_s;
            if (REGCEB) begin
                reg_b_r <= SSRB ? SRVAL_B : latch_b_r;
            end
        end
    end

    assign {DOPA, DOA} = DOA_REG ? reg_a_r : latch_a_r;
    assign {DOPB, DOB} = DOB_REG ? reg_b_r : latch_b_r;

endmodule

// File: tb/tb_ramb18_tdp.sv
// Directed bench for ramb18_tdp: two instances share stimulus, one with output registers
// (A write-first, B read-first) and one latch-only (A no-change, B write-first).
module tb_ramb18_tdp;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] addra, addrb;
    logic [15:0] dia, dib;
    logic [1:0]  dipa, dipb;
    logic        ena, enb;
    logic [1:0]  wea, web;
    logic        regcea, regceb;
    logic        ssra, ssrb;

    logic [15:0] u0_doa, u0_dob, u1_doa, u1_dob;
    logic [1:0]  u0_dopa, u0_dopb, u1_dopa, u1_dopb;
    logic [17:0] u0_a, u0_b, u1_a, u1_b;

    int cmp_count = 0;
    int err_count = 0;

    assign u0_a = {u0_dopa, u0_doa};
    assign u0_b = {u0_dopb, u0_dob};
    assign u1_a = {u1_dopa, u1_doa};
    assign u1_b = {u1_dopb, u1_dob};

    always #5 clk = ~clk;

    ramb18_tdp #(
        .DOA_REG(1'b1), .DOB_REG(1'b1),
        .INIT_A(18'h0AAAA), .INIT_B(18'h0AAAA),
        .SRVAL_A(18'h30001), .SRVAL_B(18'h15555),
        .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST")
    ) u0 (
        .clk(clk), .rst(rst), .ADDRA(addra), .ADDRB(addrb), .DIA(dia), .DIB(dib),
        .DIPA(dipa), .DIPB(dipb), .ENA(ena), .ENB(enb), .WEA(wea), .WEB(web),
        .REGCEA(regcea), .REGCEB(regceb), .SSRA(ssra), .SSRB(ssrb),
        .DOA(u0_doa), .DOB(u0_dob), .DOPA(u0_dopa), .DOPB(u0_dopb)
    );

    ramb18_tdp #(
        .DOA_REG(1'b0), .DOB_REG(1'b0),
        .INIT_A(18'h0AAAA), .INIT_B(18'h0AAAA),
        .SRVAL_A(18'h200F0), .SRVAL_B(18'h00F0F),
        .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST")
    ) u1 (
        .clk(clk), .rst(rst), .ADDRA(addra), .ADDRB(addrb), .DIA(dia), .DIB(dib),
        .DIPA(dipa), .DIPB(dipb), .ENA(ena), .ENB(enb), .WEA(wea), .WEB(web),
        .REGCEA(regcea), .REGCEB(regceb), .SSRA(ssra), .SSRB(ssrb),
        .DOA(u1_doa), .DOB(u1_dob), .DOPA(u1_dopa), .DOPB(u1_dopb)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; addra = 14'd0; addrb = 14'd0; dia = 16'h0000; dib = 16'h0000;
        dipa = 2'b00; dipb = 2'b00; ena = 1'b0; enb = 1'b0; wea = 2'b00; web = 2'b00;
        regcea = 1'b0; regceb = 1'b0; ssra = 1'b0; ssrb = 1'b0;
        #1 rst = 1'b1;
        #1;
        cmp_count++;
        if (u0_a !== 18'h0AAAA) begin err_count++; $display("FAIL reset_u0_a: got %h want %h", u0_a, 18'h0AAAA); end
        cmp_count++;
        if (u0_b !== 18'h0AAAA) begin err_count++; $display("FAIL reset_u0_b: got %h want %h", u0_b, 18'h0AAAA); end
        cmp_count++;
        if (u1_a !== 18'h0AAAA) begin err_count++; $display("FAIL reset_u1_a: got %h want %h", u1_a, 18'h0AAAA); end
        cmp_count++;
        if (u1_b !== 18'h0AAAA) begin err_count++; $display("FAIL reset_u1_b: got %h want %h", u1_b, 18'h0AAAA); end
        tick;
        tick;
        cmp_count++;
        if (u0_a !== 18'h0AAAA) begin err_count++; $display("FAIL reset_held_u0_a: got %h want %h", u0_a, 18'h0AAAA); end
        rst = 1'b0;
    endtask

    task automatic test_stream;
        logic [17:0] exp_v;
        ena = 1'b1; wea = 2'b11; regcea = 1'b1; dipa = 2'b00;
        for (int i = 0; i < 1028; i++) begin
            logic [9:0] ctr;
            logic [3:0] low;
            ctr = 10'(i);
            low = 4'(i * 3);
            addra = {ctr, low};
            dia = {6'd0, ctr};
            tick;
            if (i > 0) begin
                exp_v = {8'd0, 10'(i - 1)};
                cmp_count++;
                if (u0_a !== exp_v) begin
                    err_count++;
                    $display("FAIL stream_u0_a[%0d]: got %h want %h", i, u0_a, exp_v);
                end
            end
        end
        cmp_count++;
        if (u1_a !== 18'h0AAAA) begin err_count++; $display("FAIL stream_nochange_u1_a: got %h want %h", u1_a, 18'h0AAAA); end
        ena = 1'b0; wea = 2'b00;
    endtask

    task automatic test_read_port;
        enb = 1'b1; web = 2'b00; dib = 16'hBEEF; dipb = 2'b11; addrb = 14'd0; regceb = 1'b1;
        ena = 1'b1; wea = 2'b11; addra = 14'd0; dia = 16'h0155; dipa = 2'b00;
        tick;
        cmp_count++;
        if (u1_b !== 18'h00000) begin err_count++; $display("FAIL readport_collision_u1_b: got %h want %h", u1_b, 18'h00000); end
        ena = 1'b0; wea = 2'b00;
        tick;
        cmp_count++;
        if (u1_b !== 18'h00155) begin err_count++; $display("FAIL readport_u1_b: got %h want %h", u1_b, 18'h00155); end
        cmp_count++;
        if (u0_b !== 18'h00000) begin err_count++; $display("FAIL readport_collision_u0_b: got %h want %h", u0_b, 18'h00000); end
        tick;
        cmp_count++;
        if (u0_b !== 18'h00155) begin err_count++; $display("FAIL readport_u0_b: got %h want %h", u0_b, 18'h00155); end
        enb = 1'b0;
    endtask

    task automatic test_byte_enables;
        enb = 1'b1; regceb = 1'b1; addrb = {10'd5, 4'hF};
        dib = 16'hFFFF; dipb = 2'b11; web = 2'b11;
        tick;
        dib = 16'h1234; dipb = 2'b00; web = 2'b01;
        tick;
        cmp_count++;
        if (u1_b !== {2'b10, 16'hFF34}) begin err_count++; $display("FAIL be_writefirst_u1_b: got %h want %h", u1_b, {2'b10, 16'hFF34}); end
        web = 2'b00;
        tick;
        cmp_count++;
        if (u0_b !== 18'h3FFFF) begin err_count++; $display("FAIL be_readfirst_u0_b: got %h want %h", u0_b, 18'h3FFFF); end
        cmp_count++;
        if (u1_b !== {2'b10, 16'hFF34}) begin err_count++; $display("FAIL be_read_u1_b: got %h want %h", u1_b, {2'b10, 16'hFF34}); end
        tick;
        cmp_count++;
        if (u0_b !== {2'b10, 16'hFF34}) begin err_count++; $display("FAIL be_read_u0_b: got %h want %h", u0_b, {2'b10, 16'hFF34}); end
        web = 2'b10; dib = 16'hAB00; dipb = 2'b01;
        tick;
        cmp_count++;
        if (u1_b !== {2'b00, 16'hAB34}) begin err_count++; $display("FAIL be_upper_u1_b: got %h want %h", u1_b, {2'b00, 16'hAB34}); end
        web = 2'b00; enb = 1'b0;
    endtask

    task automatic test_write_modes;
        enb = 1'b1; regceb = 1'b1; addrb = {10'd7, 4'd0};
        web = 2'b11; dib = 16'd5; dipb = 2'b00;
        tick;
        dib = 16'd9;
        tick;
        cmp_count++;
        if (u1_b !== 18'd9) begin err_count++; $display("FAIL wm_writefirst_u1_b: got %h want %h", u1_b, 18'd9); end
        enb = 1'b0; web = 2'b00;
        tick;
        cmp_count++;
        if (u0_b !== 18'd5) begin err_count++; $display("FAIL wm_readfirst_u0_b: got %h want %h", u0_b, 18'd5); end
        cmp_count++;
        if (u1_b !== 18'd9) begin err_count++; $display("FAIL wm_en_hold_u1_b: got %h want %h", u1_b, 18'd9); end
        ena = 1'b1; regcea = 1'b1; addra = {10'd8, 4'd0}; wea = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== 18'd8) begin err_count++; $display("FAIL wm_read_u1_a: got %h want %h", u1_a, 18'd8); end
        wea = 2'b11; dia = 16'd5; dipa = 2'b00;
        tick;
        dia = 16'd9;
        tick;
        cmp_count++;
        if (u1_a !== 18'd8) begin err_count++; $display("FAIL wm_nochange_u1_a: got %h want %h", u1_a, 18'd8); end
        wea = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== 18'd9) begin err_count++; $display("FAIL wm_readback_u1_a: got %h want %h", u1_a, 18'd9); end
        cmp_count++;
        if (u0_a !== 18'd9) begin err_count++; $display("FAIL wm_writefirst_u0_a: got %h want %h", u0_a, 18'd9); end
        ena = 1'b0;
    endtask

    task automatic test_collision;
        ena = 1'b1; enb = 1'b1; addra = {10'd10, 4'd0}; addrb = {10'd10, 4'd3};
        wea = 2'b11; web = 2'b11; dia = 16'h1111; dipa = 2'b00; dib = 16'h2222; dipb = 2'b00;
        tick;
        wea = 2'b00; web = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== 18'h02222) begin err_count++; $display("FAIL coll_full_u1_a: got %h want %h", u1_a, 18'h02222); end
        wea = 2'b11; dia = 16'h3333; dipa = 2'b11;
        web = 2'b01; dib = 16'h0044; dipb = 2'b00;
        tick;
        wea = 2'b00; web = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== {2'b10, 16'h3344}) begin err_count++; $display("FAIL coll_lanes_u1_a: got %h want %h", u1_a, {2'b10, 16'h3344}); end
        ena = 1'b0; enb = 1'b0;
    endtask

    task automatic test_ssr;
        ena = 1'b1; wea = 2'b00; regcea = 1'b1; addra = {10'd8, 4'd0};
        tick;
        ssra = 1'b1;
        tick;
        cmp_count++;
        if (u0_a !== 18'h30001) begin err_count++; $display("FAIL ssr_reg_u0_a: got %h want %h", u0_a, 18'h30001); end
        cmp_count++;
        if (u1_a !== 18'h200F0) begin err_count++; $display("FAIL ssr_latch_u1_a: got %h want %h", u1_a, 18'h200F0); end
        ssra = 1'b0; regcea = 1'b0;
        tick;
        cmp_count++;
        if (u0_a !== 18'h30001) begin err_count++; $display("FAIL ssr_regce_hold_u0_a: got %h want %h", u0_a, 18'h30001); end
        regcea = 1'b1;
        tick;
        cmp_count++;
        if (u0_a !== 18'd9) begin err_count++; $display("FAIL ssr_latch_kept_u0_a: got %h want %h", u0_a, 18'd9); end
        ssra = 1'b1; wea = 2'b11; addra = {10'd11, 4'd0}; dia = 16'h0ABC; dipa = 2'b01;
        tick;
        cmp_count++;
        if (u1_a !== 18'h200F0) begin err_count++; $display("FAIL ssr_with_write_u1_a: got %h want %h", u1_a, 18'h200F0); end
        ssra = 1'b0; wea = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== {2'b01, 16'h0ABC}) begin err_count++; $display("FAIL ssr_write_done_u1_a: got %h want %h", u1_a, {2'b01, 16'h0ABC}); end
        ena = 1'b0;
    endtask

    task automatic test_reset_mid;
        tick;
        rst = 1'b1;
        #1;
        cmp_count++;
        if ({u0_a, u0_b, u1_a, u1_b} !== {4{18'h0AAAA}}) begin
            err_count++;
            $display("FAIL midreset_async: got %h %h %h %h want %h", u0_a, u0_b, u1_a, u1_b, 18'h0AAAA);
        end
        ena = 1'b1; wea = 2'b11; addra = {10'd8, 4'd0}; dia = 16'hDEAD; dipa = 2'b11; regcea = 1'b1;
        tick;
        cmp_count++;
        if (u1_a !== 18'h0AAAA) begin err_count++; $display("FAIL midreset_held_u1_a: got %h want %h", u1_a, 18'h0AAAA); end
        rst = 1'b0; wea = 2'b00;
        tick;
        cmp_count++;
        if (u1_a !== 18'd9) begin err_count++; $display("FAIL midreset_mem_kept_u1_a: got %h want %h", u1_a, 18'd9); end
        cmp_count++;
        if (u0_a !== 18'h0AAAA) begin err_count++; $display("FAIL midreset_pipe_init_u0_a: got %h want %h", u0_a, 18'h0AAAA); end
        tick;
        cmp_count++;
        if (u0_a !== 18'd9) begin err_count++; $display("FAIL midreset_pipe_u0_a: got %h want %h", u0_a, 18'd9); end
        ena = 1'b0;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_read_port;
        test_byte_enables;
        test_write_modes;
        test_collision;
        test_ssr;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
